// File: rtl/ysyx_22040383_idu_pkg.sv
// Shared definitions for the RV64I decode/issue stage.
// Contents: datapath widths, base opcodes, EXU alu_op codes, and the
// decoded bundle type that travels from the decoder to the ID/EX slot.
// Optional feature macro used by the decoder: YSYX_22040383_IDU_ILLEGAL_EN.
package ysyx_22040383_idu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      alu_op;
        logic            sub;
        logic            slt_signed;
        logic            slt_unsigned;
        logic            word_op;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } idu_bundle_t;

endpackage

// File: rtl/ysyx_22040383_idu_dec.sv
// Combinational RV64I integer decoder: instruction, pc and register
// operands in, unregistered EXU operand/control bundle out.
// Ports: inst, pc, rs1_data, rs2_data -> dec_c (idu_bundle_t).
// Macro YSYX_22040383_IDU_ILLEGAL_EN: when defined, unsupported encodings
// raise the illegal flag; otherwise the flag stays 0. Either way an illegal
// encoding decodes as ADD 0+0 with no register write.
module ysyx_22040383_idu_dec
    import ysyx_22040383_idu_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    input  logic [PC_W-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output idu_bundle_t       dec_c
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            f7_zero;
    logic            f7_alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt6;
    logic [XLEN-1:0] shamt5;

    assign opcode  = inst[6:0];
    assign rd      = inst[11:7];
    assign funct3  = inst[14:12];
    assign funct7  = inst[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);
    assign imm_i   = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u   = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign shamt6  = XLEN'(inst[25:20]);
    assign shamt5  = XLEN'(inst[24:20]);

    logic            legal;
    logic            alu_class;
    logic            reg_class;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      alu_op;
    logic            sub;
    logic            slt_s;
    logic            slt_u;
    logic            word_op;

    // Operand selection and legality per opcode class.
    always_comb begin
        legal     = 1'b0;
        alu_class = 1'b0;
        reg_class = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = ALU_ADD;
        sub       = 1'b0;
        slt_s     = 1'b0;
        slt_u     = 1'b0;
        word_op   = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_class = 1'b1;
                reg_class = 1'b1;
                a         = rs1_data;
                b         = rs2_data;
                legal     = f7_zero | (f7_alt & ((funct3 == 3'b000) | (funct3 == 3'b101)));
            end
            OPC_OP_32: begin
                alu_class = 1'b1;
                reg_class = 1'b1;
                word_op   = 1'b1;
                a         = rs1_data;
                b         = rs2_data;
                case (funct3)
                    3'b000, 3'b101: legal = f7_zero | f7_alt;
                    3'b001:         legal = f7_zero;
                    default:        legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                alu_class = 1'b1;
                a         = rs1_data;
                b         = imm_i;
                case (funct3)
                    3'b001: begin
                        b     = shamt6;
                        legal = (inst[31:26] == 6'b000000);
                    end
                    3'b101: begin
                        b     = shamt6;
                        legal = (inst[31:26] == 6'b000000) | (inst[31:26] == 6'b010000);
                    end
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                alu_class = 1'b1;
                word_op   = 1'b1;
                a         = rs1_data;
                b         = imm_i;
                case (funct3)
                    3'b000: legal = 1'b1;
                    3'b001: begin
                        b     = shamt5;
                        legal = f7_zero;
                    end
                    3'b101: begin
                        b     = shamt5;
                        legal = f7_zero | f7_alt;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                b     = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a     = XLEN'(pc);
                b     = imm_u;
            end
            default: legal = 1'b0;
        endcase

        // funct3 drives the ALU; set-less-than reuses the ADD encoding.
        if (alu_class) begin
            alu_op = {(funct3 == 3'b101) & inst[30], funct3};
            if (funct3 == 3'b010) begin
                alu_op = ALU_ADD;
                slt_s  = 1'b1;
            end
            if (funct3 == 3'b011) begin
                alu_op = ALU_ADD;
                slt_u  = 1'b1;
            end
            sub = reg_class & (funct3 == 3'b000) & f7_alt;
        end

        // Unsupported encodings collapse to a harmless ADD 0+0.
        if (!legal) begin
            a       = '0;
            b       = '0;
            alu_op  = ALU_ADD;
            sub     = 1'b0;
            slt_s   = 1'b0;
            slt_u   = 1'b0;
            word_op = 1'b0;
        end
    end

    assign dec_c.a            = a;
    assign dec_c.b            = b;
    assign dec_c.alu_op       = alu_op;
    assign dec_c.sub          = sub;
    assign dec_c.slt_signed   = slt_s;
    assign dec_c.slt_unsigned = slt_u;
    assign dec_c.word_op      = word_op;
    assign dec_c.rd           = rd;
    assign dec_c.wen          = legal & (rd != 5'd0);
`ifdef YSYX_22040383_IDU_ILLEGAL_EN
    assign dec_c.illegal      = ~legal;
`else
    assign dec_c.illegal      = 1'b0;
`endif

endmodule

// File: rtl/ysyx_22040383_idu.sv
// RV64I decode/issue stage: decodes one instruction per handshake and holds
// the EXU bundle in a single-entry ID/EX slot with valid/ready and flush.
// Ports: clk, rst_n (async active-low), flush; upstream in_valid/in_ready,
// in_inst, in_pc, in_rs1_data, in_rs2_data; downstream out_valid/out_ready,
// out_a, out_b, out_alu_op, out_sub, out_slt_signed, out_slt_unsigned,
// out_word_op, out_rd, out_wen, out_illegal.
// Macro YSYX_22040383_IDU_ILLEGAL_EN enables out_illegal (see decoder).
module ysyx_22040383_idu
    import ysyx_22040383_idu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [3:0]        out_alu_op,
    output logic              out_sub,
    output logic              out_slt_signed,
    output logic              out_slt_unsigned,
    output logic              out_word_op,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_illegal
);

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

    slot_e       state;
    idu_bundle_t dec_c;
    idu_bundle_t bundle_q;
    logic        fire;

    ysyx_22040383_idu_dec u_dec (
        .inst     (in_inst),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .dec_c    (dec_c)
    );

    // Back-pressure passes straight through from the EXU.
    assign in_ready = (state == SLOT_EMPTY) | out_ready;
    assign fire     = in_valid & in_ready;

    // Slot register; flush wins and drops any same-cycle fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SLOT_EMPTY;
            bundle_q <= '0;
        end else if (flush) begin
            state <= SLOT_EMPTY;
        end else if (fire) begin
            state    <= SLOT_FULL;
            bundle_q <= dec_c;
        end else if (out_ready) begin
            state <= SLOT_EMPTY;
        end
    end

    assign out_valid        = (state == SLOT_FULL);
    assign out_a            = bundle_q.a;
    assign out_b            = bundle_q.b;
    assign out_alu_op       = bundle_q.alu_op;
    assign out_sub          = bundle_q.sub;
    assign out_slt_signed   = bundle_q.slt_signed;
    assign out_slt_unsigned = bundle_q.slt_unsigned;
    assign out_word_op      = bundle_q.word_op;
    assign out_rd           = bundle_q.rd;
    assign out_wen          = bundle_q.wen;
    assign out_illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_ysyx_22040383_idu.sv
// Self-checking bench for ysyx_22040383_idu: directed test-plan steps then
// randomized traffic, all compared against an instruction-level model.
module tb_ysyx_22040383_idu;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  alu_op;
        logic        sub;
        logic        slt_s;
        logic        slt_u;
        logic        word_op;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [3:0]  out_alu_op;
    logic        out_sub;
    logic        out_slt_signed;
    logic        out_slt_unsigned;
    logic        out_word_op;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    int   vectors;
    int   miscompares;
    logic exp_valid;
    exp_t exp_b;

    ysyx_22040383_idu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_inst          (in_inst),
        .in_pc            (in_pc),
        .in_rs1_data      (in_rs1_data),
        .in_rs2_data      (in_rs2_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_a            (out_a),
        .out_b            (out_b),
        .out_alu_op       (out_alu_op),
        .out_sub          (out_sub),
        .out_slt_signed   (out_slt_signed),
        .out_slt_unsigned (out_slt_unsigned),
        .out_word_op      (out_word_op),
        .out_rd           (out_rd),
        .out_wen          (out_wen),
        .out_illegal      (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level reference: what the EXU should be told to do.
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                        input logic [63:0] rs1, input logic [63:0] rs2);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  f6;
        logic        is_reg;
        logic        is_imm;
        logic        is_w;
        logic        is_shift;
        logic        legal;
        logic [63:0] imm_i;
        logic [63:0] imm_u;
        opc      = inst[6:0];
        f3       = inst[14:12];
        f7       = inst[31:25];
        f6       = inst[31:26];
        is_reg   = (opc == 7'h33) || (opc == 7'h3B);
        is_imm   = (opc == 7'h13) || (opc == 7'h1B);
        is_w     = (opc == 7'h3B) || (opc == 7'h1B);
        is_shift = (f3 == 3'd1) || (f3 == 3'd5);
        imm_i    = {{52{inst[31]}}, inst[31:20]};
        imm_u    = {{32{inst[31]}}, inst[31:12], 12'h000};
        e        = '0;
        e.rd     = inst[11:7];
        legal    = 1'b0;
        if (is_reg)
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (is_imm && f3 == 3'd1)
            legal = is_w ? (f7 == 7'h00) : (f6 == 6'h00);
        else if (is_imm && f3 == 3'd5)
            legal = is_w ? (f7 == 7'h00 || f7 == 7'h20) : (f6 == 6'h00 || f6 == 6'h10);
        else if (is_imm)
            legal = 1'b1;
        else if (opc == 7'h37 || opc == 7'h17)
            legal = 1'b1;
        if (is_w && (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7))
            legal = 1'b0;
        if (legal) begin
            if (opc == 7'h37) begin
                e.b = imm_u;
            end else if (opc == 7'h17) begin
                e.a = pc;
                e.b = imm_u;
            end else begin
                e.a = rs1;
                if (is_reg)        e.b = rs2;
                else if (is_shift) e.b = is_w ? 64'(inst[24:20]) : 64'(inst[25:20]);
                else               e.b = imm_i;
                e.word_op = is_w;
                if (f3 == 3'd2)      e.slt_s = 1'b1;
                else if (f3 == 3'd3) e.slt_u = 1'b1;
                else                 e.alu_op = {f3 == 3'd5 && inst[30], f3};
                e.sub = is_reg && f3 == 3'd0 && f7 == 7'h20;
            end
            e.wen = (e.rd != 5'd0);
        end
`ifdef YSYX_22040383_IDU_ILLEGAL_EN
        e.illegal = !legal;
`endif
        return e;
    endfunction

    function automatic logic [14:0] ctrl_of(input exp_t e);
        return {e.alu_op, e.sub, e.slt_s, e.slt_u, e.word_op, e.rd, e.wen, e.illegal};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        in_valid    = v;
        in_inst     = inst;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_pc       = pc;
        out_ready   = ordy;
        flush       = fl;
    endtask

    // One clock: check in_ready, advance the slot model, check the outputs.
    task automatic tick();
        logic fire;
        logic fl;
        logic ordy;
        exp_t nxt;
        #1;
        check("in_ready", 64'(in_ready), 64'(!exp_valid || out_ready));
        fire = in_valid && (!exp_valid || out_ready);
        fl   = flush;
        ordy = out_ready;
        nxt  = ref_decode(in_inst, in_pc, in_rs1_data, in_rs2_data);
        @(posedge clk);
        #1;
        if (fl)        exp_valid = 1'b0;
        else if (fire) begin exp_valid = 1'b1; exp_b = nxt; end
        else if (ordy) exp_valid = 1'b0;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("out_a", out_a, exp_b.a);
            check("out_b", out_b, exp_b.b);
            check("ctrl", 64'({out_alu_op, out_sub, out_slt_signed, out_slt_unsigned,
                               out_word_op, out_rd, out_wen, out_illegal}), 64'(ctrl_of(exp_b)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_a"}, out_a, 64'd0);
        check({tag, "_b"}, out_b, 64'd0);
        check({tag, "_ctrl"}, 64'({out_alu_op, out_sub, out_slt_signed, out_slt_unsigned,
                                  out_word_op, out_rd, out_wen, out_illegal}), 64'd0);
    endtask

    initial begin
        logic [31:0] inst;
        vectors     = 0;
        miscompares = 0;
        exp_valid   = 1'b0;
        exp_b       = '0;
        rst_n       = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADDI x5,x1,-1 with rs1=0x10
        drive(1'b1, {12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13}, 64'h10, 64'h1234, 64'h100, 1'b1, 1'b0);
        tick();
        check("addi_a", out_a, 64'h10);
        check("addi_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_ctrl", 64'({out_alu_op, out_sub, out_word_op, out_rd, out_wen}), 64'({4'b0000, 1'b0, 1'b0, 5'd5, 1'b1}));

        // SUBW x3,x1,x2
        drive(1'b1, {7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h3B}, 64'd7, 64'd9, 64'h104, 1'b1, 1'b0);
        tick();
        check("subw_ctrl", 64'({out_alu_op, out_sub, out_word_op}), 64'({4'b0000, 1'b1, 1'b1}));

        // SRAIW x4,x4,31
        drive(1'b1, {7'h20, 5'd31, 5'd4, 3'd5, 5'd4, 7'h1B}, 64'hF0, 64'd0, 64'h108, 1'b1, 1'b0);
        tick();
        check("sraiw_op", 64'({out_alu_op, out_word_op}), 64'({4'b1101, 1'b1}));
        check("sraiw_b", out_b, 64'd31);

        // SLTU x6,x7,x8
        drive(1'b1, {7'h00, 5'd8, 5'd7, 3'd3, 5'd6, 7'h33}, 64'd1, 64'd2, 64'h10C, 1'b1, 1'b0);
        tick();
        check("sltu_flags", 64'({out_slt_unsigned, out_slt_signed, out_sub}), 64'({1'b1, 1'b0, 1'b0}));

        // AUIPC x1,0x80000 at pc 0x8000_0000
        drive(1'b1, {20'h80000, 5'd1, 7'h17}, 64'd0, 64'd0, 64'h8000_0000, 1'b1, 1'b0);
        tick();
        check("auipc_a", out_a, 64'h8000_0000);
        check("auipc_b", out_b, 64'hFFFF_FFFF_8000_0000);

        // Backpressure: three stalled cycles, held bundle, then drain+fill.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {12'h005, 5'd2, 3'd0, 5'd9, 7'h13}, 64'h55, 64'd0, 64'h110, 1'b0, 1'b0);
            tick();
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_hold_a", out_a, 64'h8000_0000);
        end
        drive(1'b1, {12'h005, 5'd2, 3'd0, 5'd9, 7'h13}, 64'h55, 64'd0, 64'h110, 1'b1, 1'b0);
        tick();
        check("refill_a", out_a, 64'h55);

        // Flush with the slot full and a same-cycle fire.
        drive(1'b1, {7'h00, 5'd3, 5'd4, 3'd4, 5'd10, 7'h33}, 64'd1, 64'd2, 64'h114, 1'b1, 1'b1);
        tick();
        check("flush_valid", 64'(out_valid), 64'd0);

        // Unsupported opcode 0x7F.
        drive(1'b1, {25'h0ABCDE, 7'h7F}, 64'hDEAD, 64'hBEEF, 64'h118, 1'b1, 1'b0);
        tick();
        check("illegal_wen", 64'(out_wen), 64'd0);
`ifdef YSYX_22040383_IDU_ILLEGAL_EN
        check("illegal_flag", 64'(out_illegal), 64'd1);
`else
        check("illegal_flag", 64'(out_illegal), 64'd0);
`endif

        // Asynchronous reset while the slot holds a bundle.
        drive(1'b1, {12'h7FF, 5'd1, 3'd6, 5'd11, 7'h13}, 64'h77, 64'd0, 64'h11C, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            inst = $urandom;
            case ($urandom_range(0, 7))
                0: inst[6:0] = 7'h33;
                1: inst[6:0] = 7'h13;
                2: inst[6:0] = 7'h3B;
                3: inst[6:0] = 7'h1B;
                4: inst[6:0] = 7'h37;
                5: inst[6:0] = 7'h17;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1)
                inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            drive(1'($urandom_range(0, 3) != 0), inst, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_22040383_idu.md
Name: ysyx_22040383_idu

Overview:
RV64I integer decode/issue stage. It accepts one fetched instruction plus register-file operands per handshake and decodes it into the operand and control bundle that the execute unit consumes: a, b, alu_op, sub, slt_signed, slt_unsigned and word_op. The decoded bundle is registered in a single-entry ID/EX pipeline slot with valid/ready flow control and flush. It is the producer end of the EXU operand/control interface.

Parameters:
XLEN, 64, datapath width; fixed at 64 (EXU width).
PC_W, 64, program-counter width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  discard the held and incoming instruction (branch or trap redirect).
in_valid  input  1  upstream presents an instruction.
in_ready  output  1  slot can accept this cycle.
in_inst  input  32  instruction word.
in_pc  input  PC_W  instruction PC.
in_rs1_data  input  XLEN  rs1 read data (combinational regfile read).
in_rs2_data  input  XLEN  rs2 read data.
out_valid  output  1  bundle valid to EXU.
out_ready  input  1  EXU accepts the bundle.
out_a  output  XLEN  EXU operand a.
out_b  output  XLEN  EXU operand b.
out_alu_op  output  4  EXU alu_op.
out_sub  output  1  subtract select.
out_slt_signed  output  1  signed set-less-than select.
out_slt_unsigned  output  1  unsigned set-less-than select.
out_word_op  output  1  32-bit W-op select.
out_rd  output  5  destination register.
out_wen  output  1  register write enable (0 when rd==0).
out_illegal  output  1  decoded encoding unsupported (feature-gated).

Behaviour:
- The reset is asynchronous and active-low. While rst_n is low: out_valid=0 and every registered output is 0, including the whole bundle, out_rd, out_wen and out_illegal.
- Slot state machine:
  - EMPTY to FULL on in_valid&&in_ready.
  - FULL to EMPTY on out_ready with no new fire.
  - FULL to FULL on simultaneous drain and fill; the new bundle is loaded the same edge.
- in_ready = ~out_valid | out_ready. This is a combinational back-path from out_ready.
- Latency is 1 cycle from accepted input to out_valid. Throughput is 1 per cycle when out_ready stays high.
- out_* are held stable while out_valid && !out_ready.
- flush has priority over everything. Next cycle out_valid=0. An input firing in the same cycle is dropped. in_ready is not gated by flush.
- Decode, with opcode = inst[6:0]:
  - OP 0110011: a=rs1, b=rs2.
  - OP-IMM 0010011: a=rs1, b=sext(imm[11:0]).
  - OP-32 0111011 and OP-IMM-32 0011011: same operands as above, with word_op=1.
  - LUI 0110111: a=0, b=sext({imm[31:12],12'b0}), alu_op=ADD.
  - AUIPC 0010111: a=pc, b=sext({imm[31:12],12'b0}), alu_op=ADD.
- alu_op encoding: alu_op[2:0]=funct3, and alu_op[3]=1 only for SRA/SRAI/SRAW/SRAIW.
  - SLT/SLTI: slt_signed=1, alu_op=ADD encoding.
  - SLTU/SLTIU: slt_unsigned=1, alu_op=ADD encoding.
  - sub=1 only for SUB/SUBW, i.e. funct7=0100000 with funct3=000 on OP or OP-32.
- At most one of sub, slt_signed and slt_unsigned is high in any bundle.
- Shift immediates:
  - OP-IMM uses shamt=inst[25:20], and funct6 must be 000000 or 010000.
  - OP-IMM-32 uses shamt=inst[24:20], and inst[25] must be 0.
  - b carries the zero-extended shamt.
- Illegal encodings: any other opcode, a funct7 not valid for the given funct3, or a W-op with funct3 in {010,011,100,110,111}.
- out_wen = legal && rd!=0.

Optional Feature:
- Macro: YSYX_22040383_IDU_ILLEGAL_EN.
- Defined: illegal encodings produce a bundle with out_illegal=1, out_wen=0, a=b=0 and alu_op=ADD. The bundle still occupies the slot and handshakes normally.
- Undefined: out_illegal is tied 0. Illegal encodings decode as ADD 0+0 with out_wen=0.

Decomposition:
- Shared package (para.v defines): opcode constants; the alu_op codes ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SRA=1101; the width macro.
- One combinational sub-module, ysyx_22040383_idu_dec: instruction + pc + rs data in, unregistered bundle out.
- The top module holds the slot register and the handshake.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately (asynchronously) and all bundle outputs 0.
- ADDI x5,x1,-1 with rs1=0x10 -> one cycle later a=0x10, b=0xFFFF_FFFF_FFFF_FFFF, alu_op=0000, sub=0, word_op=0, rd=5, wen=1.
- SUBW x3,x1,x2 -> sub=1, word_op=1, alu_op=0000. SRAIW x4,x4,31 -> alu_op=1101, word_op=1, b=31.
- SLTU x6,x7,x8 -> slt_unsigned=1, slt_signed=0, sub=0. AUIPC with pc=0x8000_0000 and imm=0x80000 -> a=0x8000_0000, b=0xFFFF_FFFF_8000_0000.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle held stable. Then raise out_ready -> drain and fill on the same edge, no bubble.
- Flush with the slot full and a fire in the same cycle -> next cycle out_valid=0. With the macro defined, opcode 0x7F -> out_illegal=1, out_wen=0.
